// File: rtl/display_pkg.sv
// Shared glyph constants and sizing helper for the 7-segment display multiplexer.
// All glyphs are active-high {a,b,c,d,e,f,g}; polarity is applied at the output register.
package display_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic int cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_mux_7seg_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high {a..g}.
// Non-decimal codes show a dash so a corrupted digit is never mistaken for a blank.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_DIGIT[0];
      4'd1: seg_o = SEG_DIGIT[1];
      4'd2: seg_o = SEG_DIGIT[2];
      4'd3: seg_o = SEG_DIGIT[3];
      4'd4: seg_o = SEG_DIGIT[4];
      4'd5: seg_o = SEG_DIGIT[5];
      4'd6: seg_o = SEG_DIGIT[6];
      4'd7: seg_o = SEG_DIGIT[7];
      4'd8: seg_o = SEG_DIGIT[8];
      4'd9: seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Four-digit MM:SS scan multiplexer with per-slot blanking and once-per-frame input snapshot.
// Optional feature: DISPLAY_BLINK_EN adds the blink input and a free-running blink phase divider.
module display_mux_7seg
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_HZ       = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [3:0] dig3,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  input  logic [3:0] dp_mask,
`ifdef DISPLAY_BLINK_EN
  input  logic       blink,
`endif
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig,
  output logic       frame_start
);

  localparam int unsigned SLOT      = CLK_HZ / SCAN_HZ;
  localparam int          CW        = cnt_width(SLOT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [6:0]  SEG_INACT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_INACT  = SEG_ACTIVE_LOW;
  localparam logic [3:0]  DIG_INACT = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  if (BLANK_CYCLES >= SLOT || BLINK_HZ == 0) begin : g_bad_cfg
    $error("display_mux_7seg: BLANK_CYCLES must be below CLK_HZ/SCAN_HZ and BLINK_HZ nonzero");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   digs_q, digs_d;
  logic [3:0]    mask_q, mask_d;
  logic          fs_q, fs_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    dig_q, dig_d;

  logic          snap_now;
  logic          show;
  logic          blank_force;
  logic [3:0]    bcd_sel;
  logic          dp_sel;
  logic [6:0]    glyph;
  logic [3:0]    dig_act;

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int          HW   = cnt_width(HALF);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

  logic [HW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == HALF_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank_force = blink & ~phase_q;
`else
  assign blank_force = 1'b0;
`endif

  // Snapshot values are forwarded on the snapshot cycle so d1 of the new frame shows fresh data.
  always_comb begin
    snap_now = (cnt_q == '0) && (idx_q == 2'd0);
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    idx_d    = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    digs_d   = snap_now ? {dig3, dig2, dig1, dig0} : digs_q;
    mask_d   = snap_now ? dp_mask : mask_q;
    fs_d     = snap_now;

    case (idx_q)
      2'd0:    begin bcd_sel = digs_d[15:12]; dp_sel = mask_d[3]; end
      2'd1:    begin bcd_sel = digs_d[11:8];  dp_sel = mask_d[2]; end
      2'd2:    begin bcd_sel = digs_d[7:4];   dp_sel = mask_d[1]; end
      default: begin bcd_sel = digs_d[3:0];   dp_sel = mask_d[0]; end
    endcase

    show    = (cnt_q >= CNT_BLANK) && en && !blank_force;
    dig_act = show ? (4'b1000 >> idx_q) : 4'b0000;

    seg_d = SEG_ACTIVE_LOW ? ~glyph   : glyph;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_sel  : dp_sel;
    dig_d = SEG_ACTIVE_LOW ? ~dig_act : dig_act;
  end

  bcd_to_7seg u_dec (
    .bcd_i (bcd_sel),
    .seg_o (glyph)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      digs_q <= '0;
      mask_q <= '0;
      fs_q   <= 1'b0;
      seg_q  <= SEG_INACT;
      dp_q   <= DP_INACT;
      dig_q  <= DIG_INACT;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      digs_q <= digs_d;
      mask_q <= mask_d;
      fs_q   <= fs_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign dig         = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Self-checking bench for display_mux_7seg: reference model of the scan timing plus
// table-driven frames and hand sequences for reset, tearing, enable and blink.
module tb_display_mux_7seg;

  localparam int SLOT  = 16;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;
  localparam int HALF  = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [3:0] dig3, dig2, dig1, dig0, dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;
  logic       frame_start;
`ifdef DISPLAY_BLINK_EN
  logic       blink;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  // model state
  int         n;
  int         t_c, t_s;
  logic [3:0] m_snap [4];
  logic [3:0] m_mask;

  always #5 clk = ~clk;

  display_mux_7seg #(
    .CLK_HZ(16000), .SCAN_HZ(1000), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .BLINK_HZ(500)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0), .dp_mask(dp_mask),
`ifdef DISPLAY_BLINK_EN
    .blink(blink),
`endif
    .seg(seg), .dp(dp), .dig(dig), .frame_start(frame_start)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at t=%0t n=%0d: got %h expected %h", name, $time, n, act, exp);
    end
  endtask

  // One clock: predict from the spec's slot arithmetic, advance, compare at the falling edge.
  task automatic tick();
    logic [6:0] e_seg;
    logic       e_dp, e_fs, on;
    logic [3:0] e_dig;
    n++;
    t_c = (n - 1) % SLOT;
    t_s = ((n - 1) / SLOT) % 4;
    e_fs = (t_c == 0 && t_s == 0);
    if (e_fs) begin
      m_snap[0] = dig3; m_snap[1] = dig2; m_snap[2] = dig1; m_snap[3] = dig0;
      m_mask = dp_mask;
    end
    on = en && (t_c >= BLANK);
`ifdef DISPLAY_BLINK_EN
    if (blink && (((n - 1) / HALF) % 2 == 0)) on = 1'b0;
`endif
    e_seg = ~ref_glyph(m_snap[t_s]);
    e_dp  = ~m_mask[3 - t_s];
    e_dig = on ? ~(4'b1000 >> t_s) : 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("scan", {3'b0, seg, dp, dig, frame_start}, {3'b0, e_seg, e_dp, e_dig, e_fs});
  endtask

  task automatic align_frame();
    while (n % FRAME != 0) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("reset_async", {3'b0, seg, dp, dig, frame_start}, {3'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", {3'b0, seg, dp, dig, frame_start}, {3'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
    rstn = 1'b1;
    n = 0;
  endtask

  typedef struct {
    logic [3:0]      d3, d2, d1, d0, mask;
    logic [0:3][6:0] es;
    logic [0:3]      edp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int fs_seen, show_cnt;
    rstn = 1'b0; en = 1'b1;
    dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd0; dp_mask = 4'd0;
`ifdef DISPLAY_BLINK_EN
    blink = 1'b0;
`endif
    n = 0;
    m_mask = 4'd0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;

    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0100, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1011};
    vecs[1] = '{4'h1, 4'hC, 4'h5, 4'h9, 4'b0000, {7'h4F, 7'h7E, 7'h24, 7'h04}, 4'b1111};
    vecs[2] = '{4'h8, 4'h0, 4'h7, 4'h6, 4'b1011, {7'h00, 7'h01, 7'h0F, 7'h20}, 4'b0100};
    vecs[3] = '{4'hF, 4'hA, 4'h9, 4'h0, 4'b0100, {7'h7E, 7'h7E, 7'h04, 7'h01}, 4'b1011};

    // reset values, then release and first-slot blanking
    @(negedge clk);
    @(negedge clk);
    check("reset_init", {3'b0, seg, dp, dig, frame_start}, {3'b0, 7'h7F, 1'b1, 4'hF, 1'b0});
    rstn = 1'b1;
    n = 0;
    tick();
    check("first_fs", {15'b0, frame_start}, 16'd1);
    check("first_blank0", {12'b0, dig}, 16'hF);
    tick();
    check("first_blank1", {11'b0, dig, frame_start}, {11'b0, 4'hF, 1'b0});
    tick();
    check("first_show_d1", {12'b0, dig}, 16'h7);

    // reset asserted mid-slot, then restart from a blank d1 slot
    for (int i = 0; i < 20; i++) tick();
    do_reset();
    tick();
    check("rst2_fs", {11'b0, dig, frame_start}, {11'b0, 4'hF, 1'b1});

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      dig3 = vecs[v].d3; dig2 = vecs[v].d2; dig1 = vecs[v].d1; dig0 = vecs[v].d0;
      dp_mask = vecs[v].mask;
      align_frame();
      show_cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
        tick();
        if (dig != 4'hF) show_cnt++;
        if (t_c == 8) check("table_seg_dp", {8'b0, seg, dp}, {8'b0, vecs[v].es[t_s], vecs[v].edp[t_s]});
      end
      check("table_show_clks", 16'(show_cnt), 16'(4 * (SLOT - BLANK)));
    end

    // tearing: change seconds mid-frame
    dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd5; dig0 = 4'd9; dp_mask = 4'b0100;
    align_frame();
    for (int k = 0; k < 2 * SLOT + 8; k++) tick();
    dig1 = 4'd0; dig0 = 4'd0;
    while (!(t_s == 3 && t_c == 8)) tick();
    check("tear_old_d4", {9'b0, seg}, {9'b0, 7'h04});
    while (!(t_s == 2 && t_c == 8)) tick();
    check("tear_new_d3", {9'b0, seg}, {9'b0, 7'h01});
    while (!(t_s == 3 && t_c == 8)) tick();
    check("tear_new_d4", {9'b0, seg}, {9'b0, 7'h01});

    // enable dropped mid-SHOW, restored two slots later
    align_frame();
    for (int k = 0; k < SLOT + 6; k++) tick();
    en = 1'b0;
    tick();
    check("en_off_next", {12'b0, dig}, 16'hF);
    fs_seen = 0;
    for (int k = 0; k < 2 * SLOT; k++) begin
      tick();
      if (frame_start) fs_seen++;
    end
    check("en_off_no_fs", 16'(fs_seen), 16'd0);
    en = 1'b1;
    tick();
    check("en_resume_idx", {12'b0, dig}, {12'b0, ~(4'b1000 >> t_s)});

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) begin
        dig3 = 4'($urandom); dig2 = 4'($urandom);
        dig1 = 4'($urandom); dig0 = 4'($urandom);
        dp_mask = 4'($urandom);
      end
      if ($urandom_range(15) == 0) en = ~en;
      tick();
    end
    en = 1'b1;

`ifdef DISPLAY_BLINK_EN
    blink = 1'b1;
    align_frame();
    for (int k = 0; k < 4 * HALF; k++) tick();
    blink = 1'b0;
    for (int k = 0; k < FRAME; k++) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
